// File: rtl/ntt_pkg.sv
// Shared NTT constants: coefficient width, modulus and default multiplier latency.
package ntt_pkg;

  localparam int DATA_W      = 12;
  localparam int NTT_Q       = 3329;
  localparam int MUL_LATENCY = 4;

  typedef logic [DATA_W-1:0] coef_t;

  // True when a coefficient is not a canonical residue in [0, q).
  function automatic logic coef_out_of_range(input coef_t v, input int q);
    return (int'(v) >= q);
  endfunction

endpackage

// File: rtl/mul_result_fifo.sv
// Synchronous result FIFO: registered write, combinational read from the head.
// Storage is not reset; only pointers and occupancy are.
module mul_result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign do_pop = pop & ~empty;

  // Data storage: written at the tail, never cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Occupancy: simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (push && !do_pop) begin
      count <= count + (AW+1)'(1);
    end else if (!push && do_pop) begin
      count <= count - (AW+1)'(1);
    end
  end

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/mul_stream_ctrl.sv
// Streaming controller around the free-running modular multiplier (q = 3329).
// Tracks in-flight operations with a valid/tag shift register matching the
// multiplier latency and buffers results in a FIFO. Because the multiplier
// cannot stall, admission is credit based: an op is accepted only if its
// result is guaranteed a FIFO slot.
// Optional build macro: MUL_RANGE_CHECK_EN adds a sticky operand-range flag.
module mul_stream_ctrl
  import ntt_pkg::*;
#(
  parameter int LATENCY    = MUL_LATENCY,
  parameter int FIFO_DEPTH = 8,
  parameter int TAG_W      = 8,
  parameter int Q          = NTT_Q
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [DATA_W-1:0] mul_in1,
  output logic [DATA_W-1:0] mul_in2,
  input  logic [DATA_W-1:0] mul_res,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              err
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int FIFO_W = DATA_W + TAG_W;

  if (LATENCY < 1 || FIFO_DEPTH < LATENCY + 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      Q < 2 || Q >= (1 << DATA_W)) begin : g_bad_cfg
    $error("mul_stream_ctrl: unsupported LATENCY/FIFO_DEPTH/Q combination");
  end

  logic               accept;
  logic               retire;
  logic [LATENCY-1:0] vld_p;
  logic [TAG_W-1:0]   tag_p [LATENCY];
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W:0]     credit_used;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_pop;
  logic [FIFO_W-1:0]  fifo_rdata;

  assign accept = in_valid & in_ready;
  assign retire = vld_p[LATENCY-1];

  // Idle cycles feed zeros so the multiplier never sees stale operands.
  assign mul_in1 = accept ? in_a : '0;
  assign mul_in2 = accept ? in_b : '0;

  // Credits come from registered state only: out_ready never reaches in_ready.
  assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
  assign in_ready    = ~fifo_full & (credit_used < (CNT_W+1)'(FIFO_DEPTH));

  // ---- tracking stages p0..p(LATENCY-1): valid bits shift in step with the multiplier
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= accept;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Tags travel with the valid bits; data-only, so no reset.
  always_ff @(posedge clk) begin
    tag_p[0] <= in_tag;
    for (int i = 1; i < LATENCY; i++) tag_p[i] <= tag_p[i-1];
  end

  // In-flight counter: +1 per accept, -1 per result retired into the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else if (accept && !retire) begin
      inflight <= inflight + CNT_W'(1);
    end else if (!accept && retire) begin
      inflight <= inflight - CNT_W'(1);
    end
  end

  // ---- result stage: push on the edge the multiplier output is sampled
  assign fifo_pop = out_valid & out_ready;

  mul_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (retire),
    .wdata ({mul_res, tag_p[LATENCY-1]}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_rdata[FIFO_W-1:TAG_W];
  assign out_tag   = fifo_rdata[TAG_W-1:0];

`ifdef MUL_RANGE_CHECK_EN
  logic err_q;

  // Sticky flag for any accepted operand outside [0, Q); the op still proceeds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept && (coef_out_of_range(in_a, Q) || coef_out_of_range(in_b, Q))) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mul_stream_ctrl.sv
// Self-checking bench for mul_stream_ctrl: behavioural multiplier in the
// environment, queue-based reference of expected results in acceptance order.
module tb_mul_stream_ctrl;

  localparam int LAT   = 4;
  localparam int DEPTH = 8;
  localparam int TW    = 8;
  localparam int QM    = 3329;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [11:0]   in_a = '0;
  logic [11:0]   in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic [11:0]   mul_in1;
  logic [11:0]   mul_in2;
  logic [11:0]   mul_res;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [11:0]   out_data;
  logic [TW-1:0] out_tag;
  logic          err;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int data;
    int tag;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  mul_stream_ctrl #(
    .LATENCY    (LAT),
    .FIFO_DEPTH (DEPTH),
    .TAG_W      (TW),
    .Q          (QM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .mul_in1   (mul_in1),
    .mul_in2   (mul_in2),
    .mul_res   (mul_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .err       (err)
  );

  // Environment: free-running LAT-stage modular multiplier, reset with rst.
  logic [11:0] mpipe [LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) mpipe[i] <= '0;
    end else begin
      mpipe[0] <= 12'((int'(mul_in1) * int'(mul_in2)) % QM);
      for (int j = 1; j < LAT; j++) mpipe[j] <= mpipe[j-1];
    end
  end
  assign mul_res = mpipe[LAT-1];

  // One clock: sample handshakes mid-cycle, update the reference, advance.
  task automatic tick(output bit acc, output bit pop, output int d, output int t);
    @(negedge clk);
    acc = (in_valid === 1'b1) && (in_ready === 1'b1);
    pop = (out_valid === 1'b1) && (out_ready === 1'b1);
    d   = int'(out_data);
    t   = int'(out_tag);
    if (acc) exp_q.push_back('{data: (int'(in_a) * int'(in_b)) % QM, tag: int'(in_tag)});
    @(posedge clk);
    #1;
  endtask

  function automatic void get_exp(output int ed, output int et, output bit ok);
    exp_t e;
    if (exp_q.size() == 0) begin
      ed = -1; et = -1; ok = 1'b0;
    end else begin
      e = exp_q.pop_front();
      ed = e.data; et = e.tag; ok = 1'b1;
    end
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid_held got=%b want=0", out_valid);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid);
    else n_pass++;
    n_checks++;
    if (out_data !== 12'd0 || out_tag !== 8'd0)
      $display("FAIL reset_out_data got=%0d/%0d want=0/0", out_data, out_tag);
    else n_pass++;
    n_checks++;
    if (err !== 1'b0) $display("FAIL reset_err got=%b want=0", err);
    else n_pass++;
  endtask

  task automatic test_single();
    bit acc, pop, ok;
    int d, t, ed, et;
    in_valid = 1'b1; in_a = 12'd17; in_b = 12'd17; in_tag = 8'h01; out_ready = 1'b1;
    #1;
    n_checks++;
    if (mul_in1 !== 12'd17 || mul_in2 !== 12'd17)
      $display("FAIL single_mul_in got=%0d,%0d want=17,17", mul_in1, mul_in2);
    else n_pass++;
    tick(acc, pop, d, t);
    n_checks++;
    if (acc !== 1'b1) $display("FAIL single_accept got=%b want=1", acc);
    else n_pass++;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (mul_in1 !== 12'd0 || mul_in2 !== 12'd0)
      $display("FAIL single_mul_in_idle got=%0d,%0d want=0,0", mul_in1, mul_in2);
    else n_pass++;
    for (int k = 0; k <= LAT; k++) begin
      tick(acc, pop, d, t);
      n_checks++;
      if (pop !== (k == LAT)) $display("FAIL single_latency edge=%0d got=%b want=%b", k, pop, (k == LAT));
      else n_pass++;
      if (pop) begin
        get_exp(ed, et, ok);
        n_checks++;
        if (!ok || d !== ed || t !== et || d !== 289)
          $display("FAIL single_data got=%0d/%0d want=%0d/%0d", d, t, ed, et);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int a_v [4] = '{3328, 2000, 1234, 0};
    int b_v [4] = '{3328, 2, 2, 5};
    bit acc, pop, ok;
    int d, t, ed, et, n_pop, first_pop, last_pop;
    n_pop = 0; first_pop = -1; last_pop = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc < 4) begin
        in_valid = 1'b1; in_a = 12'(a_v[cyc]); in_b = 12'(b_v[cyc]); in_tag = 8'(cyc + 1);
      end else begin
        in_valid = 1'b0;
      end
      tick(acc, pop, d, t);
      if (cyc < 4) begin
        n_checks++;
        if (acc !== 1'b1) $display("FAIL b2b_accept op=%0d got=%b want=1", cyc, acc);
        else n_pass++;
      end
      if (pop) begin
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        n_pop++;
        get_exp(ed, et, ok);
        n_checks++;
        if (!ok || d !== ed || t !== et) $display("FAIL b2b_data got=%0d/%0d want=%0d/%0d", d, t, ed, et);
        else n_pass++;
      end
    end
    n_checks++;
    if (n_pop !== 4 || last_pop - first_pop !== 3)
      $display("FAIL b2b_stream got=%0d pops over %0d cycles want=4 over 4", n_pop, last_pop - first_pop + 1);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bit acc, pop, ok, rdy;
    int d, t, ed, et, n_acc, n_pop, first_pop;
    n_acc = 0; n_pop = 0; first_pop = -1;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      in_valid = 1'b1;
      in_a = 12'($urandom_range(0, QM - 1));
      in_b = 12'($urandom_range(0, QM - 1));
      in_tag = 8'($urandom);
      tick(acc, pop, d, t);
      if (acc) n_acc++;
    end
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (n_acc !== DEPTH) $display("FAIL bp_accepts got=%0d want=%0d", n_acc, DEPTH);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL bp_stalled got=ready %b valid %b want=ready 0 valid 1", in_ready, out_valid);
    else n_pass++;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      rdy = in_ready;
      tick(acc, pop, d, t);
      if (pop && first_pop < 0) begin
        first_pop = cyc;
        n_checks++;
        if (rdy !== 1'b0) $display("FAIL bp_ready_before_pop got=%b want=0", rdy);
        else n_pass++;
      end else if (first_pop >= 0 && cyc == first_pop + 1) begin
        n_checks++;
        if (rdy !== 1'b1) $display("FAIL bp_ready_after_pop got=%b want=1", rdy);
        else n_pass++;
      end
      if (pop) begin
        n_pop++;
        get_exp(ed, et, ok);
        n_checks++;
        if (!ok || d !== ed || t !== et) $display("FAIL bp_data got=%0d/%0d want=%0d/%0d", d, t, ed, et);
        else n_pass++;
      end
    end
    n_checks++;
    if (n_pop !== DEPTH || exp_q.size() != 0)
      $display("FAIL bp_drain got=%0d pops %0d left want=%0d pops 0 left", n_pop, exp_q.size(), DEPTH);
    else n_pass++;
  endtask

  task automatic test_random();
    bit acc, pop, ok;
    int d, t, ed, et, n_acc, cyc;
    n_acc = 0; cyc = 0;
    out_ready = 1'b0;
    while ((n_acc < 100 || exp_q.size() > 0) && cyc < 2000) begin
      in_valid  = (n_acc < 100) && ($urandom_range(0, 3) != 0);
      in_a      = 12'($urandom_range(0, QM - 1));
      in_b      = 12'($urandom_range(0, QM - 1));
      in_tag    = 8'($urandom);
      out_ready = ~out_ready;
      tick(acc, pop, d, t);
      if (acc) n_acc++;
      if (pop) begin
        get_exp(ed, et, ok);
        n_checks++;
        if (!ok || d !== ed || t !== et) $display("FAIL rand_data got=%0d/%0d want=%0d/%0d", d, t, ed, et);
        else n_pass++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (n_acc !== 100 || exp_q.size() != 0)
      $display("FAIL rand_complete got=%0d accepted %0d outstanding want=100 accepted 0 outstanding", n_acc, exp_q.size());
    else n_pass++;
    n_checks++;
    if (err !== 1'b0) $display("FAIL rand_err got=%b want=0", err);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit acc, pop, ok;
    int d, t, ed, et, n_pop;
    n_pop = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = 12'(100 + i); in_b = 12'(3 + i); in_tag = 8'(8'hA0 + i);
      tick(acc, pop, d, t);
    end
    in_valid = 1'b0;
    tick(acc, pop, d, t);
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL rstmid_buffered got=%b want=1", out_valid);
    else n_pass++;
    rst = 1'b1;
    #1;
    exp_q.delete();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rstmid_clear got=valid %b ready %b want=valid 0 ready 1", out_valid, in_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc == 0) begin
        in_valid = 1'b1; in_a = 12'd5; in_b = 12'd7; in_tag = 8'h5A;
      end else begin
        in_valid = 1'b0;
      end
      tick(acc, pop, d, t);
      if (pop) begin
        n_pop++;
        get_exp(ed, et, ok);
        n_checks++;
        if (!ok || d !== ed || t !== et || d !== 35)
          $display("FAIL rstmid_post got=%0d/%0d want=%0d/%0d", d, t, ed, et);
        else n_pass++;
      end
    end
    n_checks++;
    if (n_pop !== 1) $display("FAIL rstmid_count got=%0d want=1", n_pop);
    else n_pass++;
  endtask

  task automatic test_err();
    bit acc, pop, ok, exp_err;
    int d, t, ed, et;
`ifdef MUL_RANGE_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    n_checks++;
    if (err !== 1'b0) $display("FAIL err_before got=%b want=0", err);
    else n_pass++;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 12'd3329; in_b = 12'd1; in_tag = 8'h77;
    tick(acc, pop, d, t);
    in_valid = 1'b0; in_a = 12'd0; in_b = 12'd0;
    n_checks++;
    if (acc !== 1'b1) $display("FAIL err_accept got=%b want=1", acc);
    else n_pass++;
    for (int cyc = 0; cyc < 8; cyc++) begin
      n_checks++;
      if (err !== exp_err) $display("FAIL err_flag cycle=%0d got=%b want=%b", cyc, err, exp_err);
      else n_pass++;
      tick(acc, pop, d, t);
      if (pop) begin
        get_exp(ed, et, ok);
        n_checks++;
        if (!ok || d !== ed || t !== et) $display("FAIL err_data got=%0d/%0d want=%0d/%0d", d, t, ed, et);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_err();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
